board_row_reader: RTL and testbench

- Read-side sequencer for the game-board point memory; the counterpart of the row write path.
- Drives the memory's row select and snapshots one 16-point row (2 bits per point).
- Streams the points out one per handshake with their coordinates.
- Feeds the VGA renderer and the win-checker; one row, or the whole board, per start.

---
 rtl/gobang_pkg.sv | 32 +++
 rtl/row_shift_buffer.sv | 42 ++++
 rtl/board_row_reader.sv | 132 +++++++++++++
 tb/tb_board_row_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gobang_pkg.sv
// Shared definitions for the gobang board datapath: board geometry, point
// encodings and the row reader's state type.
package gobang_pkg;

    localparam int BOARD_DIM = 16;
    localparam int POINT_W   = 2;
    localparam int COORD_W   = 4;
    localparam int ROW_W     = BOARD_DIM * POINT_W;

    // Index of the last point in a row and of the last row on the board.
    localparam logic [COORD_W-1:0] LAST_IDX = COORD_W'(BOARD_DIM - 1);

    typedef logic [POINT_W-1:0] point_t;

    // 2'b11 is reserved; it is passed through untouched wherever it appears.
    localparam point_t POINT_EMPTY = 2'b00;
    localparam point_t POINT_BLACK = 2'b01;
    localparam point_t POINT_WHITE = 2'b10;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_STREAM,
        RD_DONE
    } rd_state_e;

    // True when the point holds any stone (or the reserved code).
    function automatic logic is_stone(input point_t p);
        return p != POINT_EMPTY;
    endfunction

endpackage

// File: rtl/row_shift_buffer.sv
// One-row snapshot register: parallel load from the board memory, then
// shifts one point per advance so the current point always sits at the head.
module row_shift_buffer
    import gobang_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic             shift_i,
    output point_t           head_o
);

    logic [ROW_W-1:0] buf_q;
    logic [ROW_W-1:0] buf_d;

    // Next row contents: load wins over shift; zeros fill in from the top.
    always_comb begin
        // NOTE: assign a default first so every path writes buf_d and no latch is inferred.
        buf_d = buf_q;
        if (load_i) begin
            buf_d = row_i;
        end else if (shift_i) begin
            buf_d = {{POINT_W{1'b0}}, buf_q[ROW_W-1:POINT_W]};
        end
    end

    // Snapshot register.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: this is a 32-bit register, not a RAM macro, so it is cheap to
        // reset and doing so keeps point_out at a defined 0 out of reset.
        if (!reset) begin
            buf_q <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            buf_q <= buf_d;
        end
    end

    assign head_o = buf_q[POINT_W-1:0];

endmodule

// File: rtl/board_row_reader.sv
// Read-side sequencer for the board point memory. Selects a row, snapshots
// it, and streams its points out one per valid/ready handshake with their
// (x, y) coordinates; either one row or all rows per start.
// Build option: define BOARD_ROW_READER_SKIP_EMPTY_EN to suppress empty
// points from the stream (the reader still steps through them, one per cycle).
module board_row_reader
    import gobang_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               full_board,
    input  logic [COORD_W-1:0] x_in,
    input  logic               abort,
    output logic [COORD_W-1:0] row_sel,
    input  logic [ROW_W-1:0]   row_data,
    output logic [POINT_W-1:0] point_out,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic               point_valid,
    input  logic               point_ready,
    output logic               busy,
    output logic               done
);

    rd_state_e          state_q, state_d;
    logic               mode_full_q, mode_full_d;
    logic [COORD_W-1:0] row_sel_q, row_sel_d;
    logic [COORD_W-1:0] y_q, y_d;

    logic   load_buf;
    logic   shift_buf;
    point_t head;
    logic   present;
    logic   advance;

    row_shift_buffer u_buf (
        .clock   (clock),
        .reset   (reset),
        .load_i  (load_buf),
        .row_i   (row_data),
        .shift_i (shift_buf),
        .head_o  (head)
    );

`ifdef BOARD_ROW_READER_SKIP_EMPTY_EN
    // Empty points are stepped over without a handshake.
    assign present = is_stone(head);
    assign advance = !present || point_ready;
`else
    assign present = 1'b1;
    assign advance = point_ready;
`endif

    // Next-state and counter logic; abort overrides every transition.
    always_comb begin
        state_d     = state_q;
        mode_full_d = mode_full_q;
        row_sel_d   = row_sel_q;
        y_d         = y_q;
        load_buf    = 1'b0;
        shift_buf   = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (start && !abort) begin
                    mode_full_d = full_board;
                    row_sel_d   = full_board ? '0 : x_in;
                    state_d     = RD_LOAD;
                end
            end
            RD_LOAD: begin
                if (abort) begin
                    state_d = RD_IDLE;
                end else begin
                    // row_sel has been stable for a full cycle, so row_data is settled.
                    load_buf = 1'b1;
                    y_d      = '0;
                    state_d  = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (abort) begin
                    state_d = RD_IDLE;
                end else if (advance) begin
                    shift_buf = 1'b1;
                    if (y_q == LAST_IDX) begin
                        // y holds at the last index; it is cleared again in LOAD.
                        if (mode_full_q && row_sel_q != LAST_IDX) begin
                            row_sel_d = row_sel_q + 1'b1;
                            state_d   = RD_LOAD;
                        end else begin
                            state_d = RD_DONE;
                        end
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // State, mode and coordinate registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RD_IDLE;
            mode_full_q <= 1'b0;
            row_sel_q   <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            mode_full_q <= mode_full_d;
            row_sel_q   <= row_sel_d;
            y_q         <= y_d;
        end
    end

    assign row_sel     = row_sel_q;
    assign x_out       = row_sel_q;
    assign y_out       = y_q;
    assign point_out   = head;
    assign point_valid = (state_q == RD_STREAM) && present;
    assign busy        = (state_q != RD_IDLE);
    assign done        = (state_q == RD_DONE);

endmodule

// File: tb/tb_board_row_reader.sv
// Directed testbench for board_row_reader with a behavioural board memory.
module tb_board_row_reader;

`ifdef BOARD_ROW_READER_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        full_board = 1'b0;
    logic [3:0]  x_in = '0;
    logic        abort = 1'b0;
    logic [3:0]  row_sel;
    logic [31:0] row_data;
    logic [1:0]  point_out;
    logic [3:0]  x_out;
    logic [3:0]  y_out;
    logic        point_valid;
    logic        point_ready = 1'b0;
    logic        busy;
    logic        done;

    logic [31:0] mem [16];

    typedef struct packed {
        logic [1:0] p;
        logic [3:0] x;
        logic [3:0] y;
    } xfer_t;

    xfer_t got[$];
    xfer_t exp_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cyc;
    int   done_cnt;
    int   first_cyc;
    int   rowsel_bad;
    logic [3:0] rs_c1;
    bit   busy_fell;

    always #5 clock = ~clock;

    always_comb row_data = mem[row_sel];

    board_row_reader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .full_board  (full_board),
        .x_in        (x_in),
        .abort       (abort),
        .row_sel     (row_sel),
        .row_data    (row_data),
        .point_out   (point_out),
        .x_out       (x_out),
        .y_out       (y_out),
        .point_valid (point_valid),
        .point_ready (point_ready),
        .busy        (busy),
        .done        (done)
    );

    // Issue one read starting now (posedge+1 = cycle 0), record every transfer,
    // and compare the transfers against the memory model.
    task automatic run_read(input logic full, input logic [3:0] x, input bit bp,
                            input int budget, input string name);
        logic       stalled;
        xfer_t      prev;
        xfer_t      cur;
        logic [3:0] prev_rs;
        logic [1:0] p;
        int         cyc;
        int         n;

        exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            if (full || r == int'(x)) begin
                for (int y = 0; y < 16; y++) begin
                    p = mem[r][2*y +: 2];
                    if (!(SKIP && p == 2'b00)) exp_q.push_back({p, 4'(r), 4'(y)});
                end
            end
        end

        got.delete();
        done_cyc = -1; done_cnt = 0; first_cyc = -1; rowsel_bad = 0; busy_fell = 0;
        stalled = 1'b0; prev = '0;
        start = 1'b1; full_board = full; x_in = x;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        rs_c1 = row_sel;
        prev_rs = row_sel;
        while (cyc <= budget) begin
            point_ready = bp ? (cyc % 3 == 2) : 1'b1;
            cur = {point_out, x_out, y_out};
            if (stalled) begin
                n_vec++;
                if ({point_valid, cur} !== {1'b1, prev}) begin
                    n_err++;
                    $display("FAIL %s stall_hold cyc=%0d got v=%b %h want v=1 %h", name, cyc, point_valid, cur, prev);
                end
            end
            if (row_sel != prev_rs && row_sel != 4'(prev_rs + 1)) rowsel_bad++;
            prev_rs = row_sel;
            if (point_valid && point_ready) begin
                got.push_back(cur);
                if (first_cyc < 0) first_cyc = cyc;
            end
            stalled = point_valid && !point_ready;
            prev = cur;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && !busy) begin
                busy_fell = 1'b1;
                break;
            end
            @(posedge clock); #1;
            cyc++;
        end
        point_ready = 1'b0;

        n_vec++;
        if (!busy_fell) begin
            n_err++;
            $display("FAIL %s timeout: no done/idle within %0d cycles", name, budget);
        end
        n_vec++;
        if (got.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL %s xfer_count got %0d want %0d", name, got.size(), exp_q.size());
        end
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s xfer[%0d] got p=%b x=%0d y=%0d want p=%b x=%0d y=%0d",
                         name, i, got[i].p, got[i].x, got[i].y, exp_q[i].p, exp_q[i].x, exp_q[i].y);
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        n_vec++;
        if ({point_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags got %b want 000", {point_valid, busy, done});
        end
        n_vec++;
        if ({row_sel, point_out, x_out, y_out} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_fields got %h want 0", {row_sel, point_out, x_out, y_out});
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_single_row();
        mem[7] = 32'h0000_0009;
        run_read(1'b0, 4'd7, 1'b0, 40, "single_row");
        n_vec++;
        if (rs_c1 !== 4'd7) begin
            n_err++;
            $display("FAIL single_row row_sel_c1 got %0d want 7", rs_c1);
        end
        n_vec++;
        if (first_cyc !== 2) begin
            n_err++;
            $display("FAIL single_row first_valid_cycle got %0d want 2", first_cyc);
        end
        n_vec++;
        if (done_cyc !== 18 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL single_row done got cyc=%0d cnt=%0d want cyc=18 cnt=1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_skip_empty();
        // Stones only at y=2 (black) and y=14 (white).
        mem[9] = 32'h2000_0010;
        run_read(1'b0, 4'd9, 1'b0, 40, "skip_empty");
        n_vec++;
        if (first_cyc !== (SKIP ? 4 : 2)) begin
            n_err++;
            $display("FAIL skip_empty first_valid_cycle got %0d want %0d", first_cyc, SKIP ? 4 : 2);
        end
        n_vec++;
        if (done_cyc !== 18 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL skip_empty done got cyc=%0d cnt=%0d want cyc=18 cnt=1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        // Every point non-empty, including the reserved code 11.
        mem[5] = 32'h9D9D_9D9D;
        run_read(1'b0, 4'd5, 1'b1, 120, "backpressure");
        n_vec++;
        if (got.size() !== 16 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL backpressure summary got xfers=%0d dones=%0d want 16 1", got.size(), done_cnt);
        end
    endtask

    task automatic fill_mod3();
        for (int r = 0; r < 16; r++) begin
            case (r % 3)
                0:       mem[r] = 32'h0000_0000;
                1:       mem[r] = 32'h5555_5555;
                default: mem[r] = 32'hAAAA_AAAA;
            endcase
        end
    endtask

    task automatic test_full_board();
        fill_mod3();
        run_read(1'b1, 4'd9, 1'b0, 400, "full_board");
        n_vec++;
        if (done_cyc !== 273 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL full_board done got cyc=%0d cnt=%0d want cyc=273 cnt=1", done_cyc, done_cnt);
        end
        n_vec++;
        if (rowsel_bad !== 0 || rs_c1 !== 4'd0 || row_sel !== 4'd15) begin
            n_err++;
            $display("FAIL full_board row_sel_steps got bad=%0d first=%0d last=%0d want 0 0 15",
                     rowsel_bad, rs_c1, row_sel);
        end
    endtask

    task automatic test_abort();
        int seen_done;
        seen_done = 0;
        fill_mod3();
        start = 1'b1; full_board = 1'b1; x_in = 4'd0; point_ready = 1'b1;
        for (int cyc = 1; cyc <= 68; cyc++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (done) seen_done++;
            if (cyc == 10) begin
                start = 1'b1; full_board = 1'b0; x_in = 4'd9;
            end
            if (cyc == 12) begin
                n_vec++;
                if ({busy, row_sel} !== {1'b1, 4'd0}) begin
                    n_err++;
                    $display("FAIL abort start_ignored got busy=%b row_sel=%0d want 1 0", busy, row_sel);
                end
            end
        end
        // Cycle 68: the y=15 accept of row 3.
        n_vec++;
        if ({busy, point_valid, row_sel, y_out} !== {1'b1, !SKIP, 4'd3, 4'd15}) begin
            n_err++;
            $display("FAIL abort pre got busy=%b v=%b row=%0d y=%0d want 1 %b 3 15",
                     busy, point_valid, row_sel, y_out, !SKIP);
        end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        n_vec++;
        if ({busy, point_valid, done, row_sel, y_out} !== {3'b000, 4'd3, 4'd15}) begin
            n_err++;
            $display("FAIL abort post got busy=%b v=%b done=%b row=%0d y=%0d want 0 0 0 3 15",
                     busy, point_valid, done, row_sel, y_out);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (done || busy) seen_done++;
        end
        n_vec++;
        if (seen_done !== 0) begin
            n_err++;
            $display("FAIL abort no_done got %0d stray done/busy cycles want 0", seen_done);
        end
        start = 1'b1; abort = 1'b1; full_board = 1'b0; x_in = 4'd2;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        n_vec++;
        if ({busy, row_sel} !== {1'b0, 4'd3}) begin
            n_err++;
            $display("FAIL abort start_and_abort got busy=%b row_sel=%0d want 0 3", busy, row_sel);
        end
    endtask

    task automatic test_reset_mid();
        mem[7] = 32'h0000_0009;
        start = 1'b1; full_board = 1'b0; x_in = 4'd7; point_ready = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({point_valid, busy, done, row_sel, point_out, y_out} !== 13'h0) begin
            n_err++;
            $display("FAIL reset_mid got v=%b busy=%b done=%b row=%0d p=%b y=%0d want all 0",
                     point_valid, busy, done, row_sel, point_out, y_out);
        end
        #2;
        reset = 1'b1;
        point_ready = 1'b0;
        @(posedge clock); #1;
        run_read(1'b0, 4'd7, 1'b0, 40, "reset_mid_restart");
        n_vec++;
        if (done_cyc !== 18) begin
            n_err++;
            $display("FAIL reset_mid_restart done_cycle got %0d want 18", done_cyc);
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) mem[r] = '0;
        test_reset();
        test_single_row();
        test_skip_empty();
        test_backpressure();
        test_full_board();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
